// File: rtl/rip_axi_rd_arbiter.sv
// rtl/rip_axi_rd_arbiter.sv - two-requester round-robin AXI4 read arbiter, one outstanding burst
//
// Ports:
//   clk, sys_rst_n         : clock, synchronous active-low reset
//   s_arvalid/s_araddr/s_arlen/s_arready : per-requester read requests (0 = fetch, 1 = data)
//   s_rdata/s_rresp/s_rlast, s_rvalid/s_rready : shared read-data return, per-requester handshake
//   AR* / R*               : AXI4 read master channels
//   busy                   : high whenever the FSM is not IDLE
//   err, err_owner         : sticky response/ID error flag and first failing owner
//                            (present only when RIP_ARB_ERR_EN is defined)
module rip_axi_rd_arbiter #(
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        sys_rst_n,
    input  logic [1:0]                  s_arvalid,
    input  logic [2*AXI_ADDR_WIDTH-1:0] s_araddr,
    input  logic [15:0]                 s_arlen,
    output logic [1:0]                  s_arready,
    output logic [AXI_DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]                  s_rresp,
    output logic                        s_rlast,
    output logic [1:0]                  s_rvalid,
    input  logic [1:0]                  s_rready,
    output logic [AXI_ID_WIDTH-1:0]     ARID,
    output logic [AXI_ADDR_WIDTH-1:0]   ARADDR,
    output logic [7:0]                  ARLEN,
    output logic [2:0]                  ARSIZE,
    output logic [1:0]                  ARBURST,
    output logic                        ARLOCK,
    output logic [3:0]                  ARCACHE,
    output logic [2:0]                  ARPROT,
    output logic [3:0]                  ARQOS,
    output logic [3:0]                  ARREGION,
    output logic                        ARVALID,
    input  logic                        ARREADY,
    input  logic [AXI_ID_WIDTH-1:0]     RID,
    input  logic [AXI_DATA_WIDTH-1:0]   RDATA,
    input  logic [1:0]                  RRESP,
    input  logic                        RLAST,
    input  logic                        RVALID,
    output logic                        RREADY,
`ifdef RIP_ARB_ERR_EN
    output logic                        err,
    output logic                        err_owner,
`endif
    output logic                        busy
);

    localparam int AW = AXI_ADDR_WIDTH;
    localparam logic [2:0] AR_SIZE = 3'($clog2(AXI_DATA_WIDTH / 8));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic          last_grant;
    logic          owner;
    logic [AW-1:0] addr_q;
    logic [7:0]    len_q;
    logic          grant_idx;
    logic          grant_en;
    logic          beat_acc;
    logic          burst_done;

    // On a tie the requester not granted last wins; otherwise the only valid one.
    always_comb begin
        grant_idx = ~s_arvalid[0];
        if (s_arvalid == 2'b11) begin
            grant_idx = ~last_grant;
        end
    end

    assign grant_en   = (state == IDLE) && (|s_arvalid);
    assign beat_acc   = (state == DATA) && RVALID && RREADY;
    assign burst_done = beat_acc && RLAST;

    always_ff @(posedge clk) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            addr_q     <= '0;
            len_q      <= '0;
        end else begin
            state <= state_nxt;
            if (grant_en) begin
                owner  <= grant_idx;
                addr_q <= grant_idx ? s_araddr[2*AW-1:AW] : s_araddr[AW-1:0];
                len_q  <= grant_idx ? s_arlen[15:8] : s_arlen[7:0];
            end
            if (burst_done) begin
                last_grant <= owner;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        s_arready = 2'b00;
        ARVALID   = 1'b0;
        RREADY    = 1'b0;
        s_rvalid  = 2'b00;
        case (state)
            IDLE: begin
                if (grant_en) begin
                    s_arready = grant_idx ? 2'b10 : 2'b01;
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                ARVALID = 1'b1;
                if (ARREADY) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                // Routing follows the latched owner only; RID is never consulted.
                RREADY   = owner ? s_rready[1] : s_rready[0];
                s_rvalid = owner ? {RVALID, 1'b0} : {1'b0, RVALID};
                if (burst_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy     = (state != IDLE);
    assign s_rdata  = RDATA;
    assign s_rresp  = RRESP;
    assign s_rlast  = RLAST;

    assign ARID     = AXI_ID_WIDTH'(owner);
    assign ARADDR   = addr_q;
    assign ARLEN    = len_q;
    assign ARSIZE   = AR_SIZE;
    assign ARBURST  = 2'b01;
    assign ARLOCK   = 1'b0;
    assign ARCACHE  = 4'd0;
    assign ARPROT   = 3'd0;
    assign ARQOS    = 4'd0;
    assign ARREGION = 4'd0;

`ifdef RIP_ARB_ERR_EN
    always_ff @(posedge clk) begin
        if (!sys_rst_n) begin
            err       <= 1'b0;
            err_owner <= 1'b0;
        end else if (beat_acc && ((RRESP != 2'b00) || (RID != ARID))) begin
            err <= 1'b1;
            // Only the first failing owner is recorded.
            if (!err) begin
                err_owner <= owner;
            end
        end
    end
`else
    logic unused_rid;
    assign unused_rid = ^RID;
`endif

endmodule

// File: doc/rip_axi_rd_arbiter.md
RIP_AXI_RD_ARBITER -- requirements
Module: rip_axi_rd_arbiter

Interface
REQ-001 The block SHALL have parameter AXI_ID_WIDTH, default 4, giving the ARID/RID width.
REQ-002 The block SHALL have parameter AXI_ADDR_WIDTH, default 32, giving the address width (AW).
REQ-003 The block SHALL have parameter AXI_DATA_WIDTH, default 32, giving the data width (DW).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port sys_rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port s_arvalid, input, 2 bits: per-requester read request (bit0 = fetch, bit1 = data).
REQ-007 The block SHALL have port s_araddr, input, 2*AW bits: per-requester address, requester i in slice [i*AW +: AW].
REQ-008 The block SHALL have port s_arlen, input, 16 bits: per-requester AXI burst length, slice [i*8 +: 8].
REQ-009 The block SHALL have port s_arready, output, 2 bits: per-requester request accept.
REQ-010 The block SHALL have ports s_rdata (output, DW), s_rresp (output, 2) and s_rlast (output, 1): shared read-data return.
REQ-011 The block SHALL have ports s_rvalid (output, 2) and s_rready (input, 2): per-requester beat handshake.
REQ-012 The block SHALL have master ports ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS, ARREGION, ARVALID (outputs) and ARREADY (input), all AXI4-width.
REQ-013 The block SHALL have master ports RID, RDATA, RRESP, RLAST, RVALID (inputs) and RREADY (output), all AXI4-width.
REQ-014 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not IDLE.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, ADDR and DATA, with at most one outstanding burst.
REQ-016 In IDLE, when any s_arvalid bit is set, the block SHALL grant one requester, pulse its s_arready for exactly that cycle, latch that requester's address, length and owner index, and go to ADDR.
REQ-017 Arbitration SHALL be round-robin: when both requesters are valid, the one not granted last wins; the last-granted pointer resets to 1, so requester 0 wins the first tie.
REQ-018 In ADDR, ARVALID SHALL be 1 with the latched fields held stable; on ARVALID&ARREADY the FSM SHALL go to DATA.
REQ-019 ARVALID SHALL first rise exactly one cycle after the granting s_arready pulse.
REQ-020 The AR fields SHALL be: ARID = owner index zero-extended to AXI_ID_WIDTH, ARSIZE = log2(DW/8), ARBURST = 2'b01 (INCR), and ARLOCK/ARCACHE/ARPROT/ARQOS/ARREGION = 0.
REQ-021 In DATA, the read-data path SHALL be combinational (zero latency):
  - s_rvalid[owner] = RVALID, and the other s_rvalid bit = 0;
  - RREADY = s_rready[owner];
  - s_rdata/s_rresp/s_rlast = RDATA/RRESP/RLAST.
REQ-022 On RVALID&RREADY&RLAST in DATA, the FSM SHALL return to IDLE and set the last-granted pointer to owner; a new grant is possible in the following cycle.
REQ-023 Outside DATA, RREADY and s_rvalid SHALL be 0, and s_arready SHALL be 0 outside IDLE.
REQ-024 s_arvalid asserted while busy SHALL be held off (no s_arready) and SHALL be served on the IDLE cycle after the burst ends.
REQ-025 RID SHALL NOT affect routing; routing uses only the latched owner.

Reset
REQ-026 While sys_rst_n = 0 at a rising edge, the block SHALL clear the FSM to IDLE, set the last-granted pointer to 1, and clear latched fields to 0.
REQ-027 Output reset values SHALL be: ARVALID = 0, RREADY = 0, s_arready = 0, s_rvalid = 0, busy = 0, ARADDR/ARLEN/ARID = 0; ARSIZE and ARBURST keep their constant values.
REQ-028 Reset mid-burst SHALL abandon the transaction without completing it; the AXI slave is reset in the same domain.

Configuration
REQ-029 With macro RIP_ARB_ERR_EN defined, the block SHALL add outputs err (1 bit) and err_owner (1 bit).
  - err is sticky: it is set on any accepted beat with RRESP != 0 or RID != ARID.
  - err_owner captures the owner index on the first error.
  - Both are cleared only by reset.
REQ-030 Without RIP_ARB_ERR_EN, these ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 Scenario single fetch: s_arvalid=01, addr0=0x1000, len0=3, ARREADY=1 -> ARVALID one cycle after the s_arready[0] pulse, ARADDR=0x1000, ARLEN=3, ARID=0; 4 beats appear on s_rvalid[0]; busy falls after the RLAST beat.
REQ-032 Scenario tie after reset: s_arvalid=11 -> requester 0 granted first and requester 1 next, with ARID 0 then 1.
REQ-033 Scenario round-robin: requester 1 is held valid while requester 0 re-requests continuously -> grants alternate 0,1,0,1.
REQ-034 Scenario backpressure: ARREADY held low 5 cycles -> ARVALID/ARADDR stable all 5 cycles; s_rready[1]=0 for 3 cycles in DATA -> RREADY=0, beat held, no loss.
REQ-035 Scenario reset mid-burst: sys_rst_n=0 during beat 2 of len=7 -> next cycle IDLE, busy=0, RREADY=0, pointer=1.
REQ-036 Scenario error (RIP_ARB_ERR_EN defined): owner 1 receives RRESP=2'b10 on beat 0 -> err=1 and err_owner=1, held after the burst ends.
